// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Row drive patterns are active-low one-hot, row 0 in the MSB.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    HELD,
    REL_PEND
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_cls_t;

  localparam logic [3:0] ROW0 = 4'b0111;
  localparam logic [3:0] ROW1 = 4'b1011;
  localparam logic [3:0] ROW2 = 4'b1101;
  localparam logic [3:0] ROW3 = 4'b1110;

  function automatic logic [3:0] row_drive(
    input logic [1:0] idx
  );
    logic [3:0] r;
    case (idx)
      2'd0:    r = ROW0;
      2'd1:    r = ROW1;
      2'd2:    r = ROW2;
      default: r = ROW3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Reset value is a parameter so idle pulled-up lines stay inactive.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotating row drive, per-scan press map,
// anti-ghosting classification and press/release debounce FSM.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 8192,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_THR = CW'(DEBOUNCE_SCANS);

  logic [3:0] w_col_s;
  logic [3:0] w_hits;
  logic       w_slot_end;

  logic [DW-1:0] r_div;
  logic [1:0]    r_ridx;
  logic [3:0]    r_row;
  logic          r_scan_done;
  logic [15:0]   r_map;

  sync2 #(
    .W       (4),
    .RST_VAL (4'hF)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (col),
    .o_q (w_col_s)
  );

  // col[3] is column 0, so reverse into column order
  assign w_hits = ~{w_col_s[0], w_col_s[1], w_col_s[2], w_col_s[3]};
  assign w_slot_end = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_ridx      <= '0;
      r_row       <= ROW0;
      r_scan_done <= 1'b0;
      r_map       <= '0;
    end else begin
      r_scan_done <= w_slot_end && (r_ridx == 2'd3);
      if (w_slot_end) begin
        r_div  <= '0;
        r_ridx <= r_ridx + 2'd1;
        r_row  <= row_drive(r_ridx + 2'd1);
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (r_scan_done) begin
        r_map <= '0;
      end else if (w_slot_end) begin
        r_map <= r_map | ({12'd0, w_hits} << {r_ridx, 2'b00});
      end
    end
  end

  logic [4:0] w_ones;
  logic [3:0] w_idx;
  scan_cls_t  w_cls;

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_map[i]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(i);
      end
    end
    w_cls = MULTI;
    if (w_ones == 5'd0) begin
      w_cls = NONE;
    end else if (w_ones == 5'd1) begin
      w_cls = SINGLE;
    end
  end

  kp_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic [3:0]    r_key;
  logic          r_valid;
  logic          r_held;
  logic [CW-1:0] w_cnt_inc;
  logic          w_same;
  logic          w_thr;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_thr     = (w_cnt_inc == CNT_THR);
  assign w_same    = (w_cls == SINGLE) && (w_idx == r_cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_scan_done) begin
        case (r_state)
          IDLE: begin
            if (w_cls == SINGLE) begin
              r_cand  <= w_idx;
              r_cnt   <= CW'(1);
              r_state <= PRESS_PEND;
            end
          end
          PRESS_PEND: begin
            if (!w_same) begin
              r_state <= IDLE;
            end else if (w_thr) begin
              r_key   <= r_cand;
              r_valid <= 1'b1;
              r_held  <= 1'b1;
              r_state <= HELD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          HELD: begin
            // only a fully empty scan starts release
            if (w_cls == NONE) begin
              r_cnt   <= CW'(1);
              r_state <= REL_PEND;
            end
          end
          REL_PEND: begin
            if (w_cls != NONE) begin
              r_state <= HELD;
            end else if (w_thr) begin
              r_held  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign row       = r_row;
  assign key       = r_key;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed scan table plus randomized scans
// checked against a scan-level keypad behaviour model.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // physical keypad: a pressed switch pulls its column low on its row
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row == ~(4'b1000 >> r)) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4+c]) col[3-c] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) @(negedge clk);
    check("rst_row", int'(row), int'(4'b0111));
    check("rst_key", int'(key), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    rst = 1'b0;
  endtask

  // One full scan window starting at row 0, divider 0.
  task automatic run_scan(input logic [15:0] map, input int ev,
                          input logic [3:0] ek, input logic eh,
                          input string tag);
    int nv;
    int pos;
    int row_bad;
    logic [3:0] kk;
    logic hh;
    pressed = map;
    nv = 0;
    pos = -1;
    row_bad = 0;
    kk = '0;
    hh = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (row !== ~(4'b1000 >> (i / 4))) row_bad++;
      if (key_valid === 1'b1) begin
        nv++;
        if (pos < 0) pos = i;
      end
      if (i == 15) begin
        kk = key;
        hh = key_held;
      end
      @(negedge clk);
    end
    check({tag, "_row"}, row_bad, 0);
    check({tag, "_npulse"}, nv, ev);
    if (ev > 0) check({tag, "_pulse_pos"}, pos, 1);
    check({tag, "_key"}, int'(kk), int'(ek));
    check({tag, "_held"}, int'(hh), int'(eh));
  endtask

  typedef struct {
    logic        rst_before;
    logic [15:0] map;
    int          ev;
    logic [3:0]  ek;
    logic        eh;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [15:0] m, input int v,
                     input logic [3:0] k, input logic h);
    vec_t e;
    e.rst_before = r;
    e.map = m;
    e.ev = v;
    e.ek = k;
    e.eh = h;
    tbl.push_back(e);
  endtask

  // scan-level model state
  logic       m_held;
  int         m_run;
  int         m_cand;
  int         e_v;
  logic [3:0] e_k;
  logic       e_h;

  task automatic model_reset();
    m_held = 1'b0;
    m_run = 0;
    m_cand = 0;
    e_v = 0;
    e_k = 4'h0;
    e_h = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] map);
    int ones;
    int k;
    ones = $countones(map);
    k = 0;
    for (int i = 0; i < 16; i++) if (map[i]) k = i;
    e_v = 0;
    if (!m_held) begin
      if (ones == 1 && m_run > 0 && k == m_cand) m_run++;
      else if (ones == 1 && m_run == 0) begin
        m_cand = k;
        m_run = 1;
      end else m_run = 0;
      if (m_run == DB) begin
        e_v = 1;
        e_k = 4'(m_cand);
        e_h = 1'b1;
        m_held = 1'b1;
        m_run = 0;
      end
    end else begin
      if (ones == 0) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        e_h = 1'b0;
        m_held = 1'b0;
        m_run = 0;
      end
    end
  endtask

  initial begin
    // idle free-run
    add(0, 16'h0000, 0, 4'h0, 0);
    add(0, 16'h0000, 0, 4'h0, 0);
    // key 9 pressed 5 scans, released 4
    add(0, 16'h0200, 0, 4'h0, 0);
    add(0, 16'h0200, 0, 4'h0, 0);
    add(0, 16'h0200, 0, 4'h0, 0);
    add(0, 16'h0200, 1, 4'h9, 1);
    add(0, 16'h0200, 0, 4'h9, 1);
    add(0, 16'h0000, 0, 4'h9, 1);
    add(0, 16'h0000, 0, 4'h9, 1);
    add(0, 16'h0000, 0, 4'h9, 1);
    add(0, 16'h0000, 0, 4'h9, 0);
    // bounce
    add(0, 16'h0200, 0, 4'h9, 0);
    add(0, 16'h0000, 0, 4'h9, 0);
    add(0, 16'h0200, 0, 4'h9, 0);
    add(0, 16'h0200, 0, 4'h9, 0);
    add(0, 16'h0000, 0, 4'h9, 0);
    add(0, 16'h0000, 0, 4'h9, 0);
    // ghosting pair on row 0
    for (int i = 0; i < 6; i++) add(0, 16'h0005, 0, 4'h9, 0);
    add(0, 16'h0000, 0, 4'h9, 0);
    // key F, then extra keys while held
    add(0, 16'h8000, 0, 4'h9, 0);
    add(0, 16'h8000, 0, 4'h9, 0);
    add(0, 16'h8000, 0, 4'h9, 0);
    add(0, 16'h8200, 1, 4'hF, 1);
    add(0, 16'h8200, 0, 4'hF, 1);
    add(0, 16'h0008, 0, 4'hF, 1);
    add(0, 16'h0000, 0, 4'hF, 1);
    add(0, 16'h0000, 0, 4'hF, 1);
    add(0, 16'h0000, 0, 4'hF, 1);
    add(0, 16'h0000, 0, 4'hF, 0);
    // key 5 with reset in the middle of the debounce
    add(0, 16'h0020, 0, 4'hF, 0);
    add(0, 16'h0020, 0, 4'hF, 0);
    add(1, 16'h0020, 0, 4'h0, 0);
    add(0, 16'h0020, 0, 4'h0, 0);
    add(0, 16'h0020, 0, 4'h0, 0);
    add(0, 16'h0000, 1, 4'h5, 1);
    add(0, 16'h0000, 0, 4'h5, 1);
    add(0, 16'h0000, 0, 4'h5, 1);
    add(0, 16'h0000, 0, 4'h5, 0);

    do_reset(3);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset(1);
      run_scan(tbl[i].map, tbl[i].ev, tbl[i].ek, tbl[i].eh,
               $sformatf("vec%0d", i));
    end

    // randomized runs of scan patterns
    do_reset(1);
    model_reset();
    begin
      int n;
      n = 0;
      while (n < 70) begin
        int kind;
        int len;
        int a;
        int b;
        logic [15:0] m;
        kind = int'($urandom_range(0, 4));
        len = int'($urandom_range(1, 5));
        a = int'($urandom_range(0, 15));
        b = (a + int'($urandom_range(1, 15))) % 16;
        m = '0;
        case (kind)
          0: m = '0;
          1, 2: m[a] = 1'b1;
          default: begin
            m[a] = 1'b1;
            m[b] = 1'b1;
          end
        endcase
        for (int j = 0; j < len; j++) begin
          run_scan(m, e_v, e_k, e_h, $sformatf("rnd%0d", n));
          model_step(m);
          n++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart of the 4-digit multiplexed 7-segment driver.
- Drives a 4x4 matrix keypad one row at a time, active-low and one-hot, using the same rotating-enable scheme as the digit enables.
- Samples the columns, debounces across full scans and reports each clean key press as a 4-bit hex code with a one-cycle strobe.
- Feeds the clock's time-setting logic; its codes can be shown directly as hex digits on the display.

Parameters:
- SCAN_DIV, 8192, clock cycles each row stays driven; minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- col  in  4  keypad columns; active-low, externally pulled up, asynchronous. col[3] is column 0, col[0] is column 3.
- row  out  4  row drive; active-low one-hot. Row 0 = 4'b0111, row 1 = 4'b1011, row 2 = 4'b1101, row 3 = 4'b1110.
- key  out  4  code of the last accepted key = {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  one-cycle pulse when a new press is accepted.
- key_held  out  1  high while the accepted key is considered down.

Behaviour:
- Reset values:
  - row = 4'b0111; divider = 0; press map cleared; FSM in IDLE.
  - key = 4'h0; key_valid = 0; key_held = 0.
  - Reset mid-operation discards any pending press or release and emits no key_valid.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1, then wraps and advances the row index 0→1→2→3→0.
  - Full scan = 4*SCAN_DIV cycles.
- Column path:
  - col passes through a 2-flop synchronizer.
  - The synced value is sampled on divider == SCAN_DIV-1 of each row slot, giving settle time after a row change.
  - The sample is written into a 16-bit press map; bit {row_idx, col_idx} is set when that column reads low.
- Scan result:
  - scan_done pulses in the cycle after the row-3 sample.
  - On scan_done, the press map is classified as NONE (0 bits set), SINGLE(k) (exactly 1 bit set) or MULTI (2 or more bits set).
  - MULTI is treated as NONE for acceptance (anti-ghosting).
  - The press map is cleared for the next scan on the same edge.
- FSM transitions, evaluated only on scan_done:
  - IDLE: SINGLE(k) → cand = k, cnt = 1, go to PRESS_PEND. Anything else → stay.
  - PRESS_PEND:
    - SINGLE(cand) → cnt + 1. When cnt reaches DEBOUNCE_SCANS: key = cand, key_valid = 1 for one cycle, key_held = 1, go to HELD.
    - Any other result → go to IDLE, no output change.
  - HELD:
    - NONE (strictly 0 bits) → cnt = 1, go to REL_PEND.
    - SINGLE or MULTI (including a different key) → stay. No new event until a release is accepted.
  - REL_PEND:
    - NONE → cnt + 1. When cnt reaches DEBOUNCE_SCANS: key_held = 0, go to IDLE.
    - Anything else → back to HELD.
- Latency:
  - key_valid rises one cycle after the scan_done of the DEBOUNCE_SCANS-th consecutive matching scan.
  - key keeps its value after release until the next accepted press.
- key_valid and key_held are registered outputs and never glitch.
- cnt is wide enough for DEBOUNCE_SCANS and cannot overflow, since every state exits at the threshold.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum: IDLE, PRESS_PEND, HELD, REL_PEND.
  - Row drive constants ROW0..ROW3.
  - Scan-result class enum: NONE, SINGLE, MULTI.
- One sub-module, sync2: a generic 2-flop synchronizer, width-parameterized, used for col.
- Classification and the FSM stay in keypad_scan.

Test Plan (SCAN_DIV = 4, DEBOUNCE_SCANS = 3, so one scan = 16 cycles):
- Reset, then free-run with col = 4'b1111 → row steps 0111, 1011, 1101, 1110, 4 cycles each, repeating. key_valid = 0, key_held = 0 and key = 0 throughout.
- Model row 2 / col 1 pressed (col = 4'b1011 whenever row == 1101) for 5 scans, then release for 4 scans:
  - Exactly one key_valid pulse, key = 4'h9, one cycle after the 3rd scan_done.
  - key_held = 1 until 3 NONE scans have completed, then 0.
  - key stays 4'h9.
- Bounce: press for 1 scan, release for 1 scan, press for 2 scans, release → no key_valid and key_held stays 0.
- Row 0 col 0 and row 0 col 2 pressed together (col = 4'b0101 on row 0111) for 6 scans → no key_valid. Then, from HELD on key 4'hF, add a second key → no extra pulse.
- Hold key 4'h5 for 2 scans, assert rst for 1 cycle, keep holding → no pulse before reset; all outputs at reset values; key_valid fires after the 3rd post-reset scan.
- Press row 3 / col 3 (col = 4'b1110 on row 1110) → key = 4'hF with a single key_valid pulse.
